alu_mul_sequencer: RTL

- Multi-cycle controller that computes a 32x32 -> low-32 product (RV32M MUL semantics) by sequencing the shared integer ALU through shift-and-add.
- Sits beside the execute stage. It owns the ALU operand and opcode inputs while busy and reads the ALU result combinationally.
- The ALU instance lives in the parent, which muxes ALU inputs between this block and the normal datapath using busy.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu.sv | 39 +++
 rtl/alu_mul_sequencer.sv | 113 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings and the multiply sequencer state type.
package alu_pkg;

    // ALU operation encodings
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_SLT = 4'b0101;
    localparam logic [3:0] ALU_SLL = 4'b0110;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_EQ  = 4'b1000;
    localparam logic [3:0] ALU_SRA = 4'b1001;
    localparam logic [3:0] ALU_BGE = 4'b1010;
    localparam logic [3:0] ALU_BNE = 4'b1011;

    // Shift-and-add multiply sequencer states
    typedef enum logic [1:0] {
        IDLE,
        ADD,
        SHIFT,
        DONE
    } mul_state_t;

endpackage

// File: rtl/alu.sv
// Shared integer ALU: purely combinational, result follows src_a/src_b/operation.
module alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic [DATA_WIDTH-1:0]    src_a,
    input  logic [DATA_WIDTH-1:0]    src_b,
    input  logic [OPCODE_LENGTH-1:0] operation,
    output logic [DATA_WIDTH-1:0]    result
);

    localparam int SHW = $clog2(DATA_WIDTH);

    logic [SHW-1:0] shamt;
    assign shamt = src_b[SHW-1:0];

    // Decode the operation; comparisons return 0/1 in the low bit
    always_comb begin
        result = '0;
        case (operation)
            ALU_AND: result = src_a & src_b;
            ALU_OR:  result = src_a | src_b;
            ALU_ADD: result = src_a + src_b;
            ALU_XOR: result = src_a ^ src_b;
            ALU_SUB: result = src_a - src_b;
            ALU_SLT: result = {{(DATA_WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            ALU_SLL: result = src_a << shamt;
            ALU_SRL: result = src_a >> shamt;
            ALU_EQ:  result = {{(DATA_WIDTH-1){1'b0}}, src_a == src_b};
            ALU_SRA: result = $signed(src_a) >>> shamt;
            ALU_BGE: result = {{(DATA_WIDTH-1){1'b0}}, $signed(src_a) >= $signed(src_b)};
            ALU_BNE: result = {{(DATA_WIDTH-1){1'b0}}, src_a != src_b};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_mul_sequencer.sv
// Multi-cycle low-word multiplier that borrows the shared ALU for shift-and-add.
// One ADD/SHIFT pair per multiplier bit; the parent muxes ALU inputs on busy.
module alu_mul_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter bit EARLY_EXIT    = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [DATA_WIDTH-1:0]    op_a,
    input  logic [DATA_WIDTH-1:0]    op_b,
    output logic                     busy,
    output logic                     done,
    output logic [DATA_WIDTH-1:0]    product,
    output logic [DATA_WIDTH-1:0]    alu_src_a,
    output logic [DATA_WIDTH-1:0]    alu_src_b,
    output logic [OPCODE_LENGTH-1:0] alu_op,
    input  logic [DATA_WIDTH-1:0]    alu_result
);

    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    mul_state_t            state_q, state_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
    logic [DATA_WIDTH-1:0] mplr_q, mplr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] product_q, product_d;

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplr_q    <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplr_q    <= mplr_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    // Next-state logic and ALU drive for each phase of the shift-and-add loop
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplr_d    = mplr_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        alu_op    = OPCODE_LENGTH'(ALU_AND);
        alu_src_a = '0;
        alu_src_b = '0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    mcand_d = op_a;
                    mplr_d  = op_b;
                    cnt_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                alu_op    = OPCODE_LENGTH'(ALU_ADD);
                alu_src_a = acc_q;
                alu_src_b = mcand_q;
                if (mplr_q[0]) begin
                    acc_d = alu_result;
                end
                state_d = SHIFT;
            end
            SHIFT: begin
                alu_op    = OPCODE_LENGTH'(ALU_SLL);
                alu_src_a = mcand_q;
                alu_src_b = DATA_WIDTH'(1);
                mcand_d   = alu_result;
                // Multiplier shifts locally; the ALU is busy doubling the multiplicand
                mplr_d    = mplr_q >> 1;
                cnt_d     = cnt_q + CNT_W'(1);
                if ((cnt_q == CNT_LAST) || (EARLY_EXIT && (mplr_d == '0))) begin
                    // acc is final here: the last ADD already committed
                    product_d = acc_q;
                    state_d   = DONE;
                end else begin
                    state_d = ADD;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign product = product_q;

endmodule
